// File: rtl/voxel_fetch_master_if.sv
// Bus bundle for voxel_fetch_master: Avalon-MM byte read port (m1) and the
// 32-bit word stream toward the renderer.
interface voxel_fetch_master_if;
  logic [31:0] m1_address;
  logic        m1_read;
  logic        m1_waitrequest;
  logic [7:0]  m1_readdata;
  logic        m1_readdatavalid;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output m1_address, m1_read,
    input  m1_waitrequest, m1_readdata, m1_readdatavalid,
    output out_data, out_valid,
    input  out_ready
  );

  modport slave (
    input  m1_address, m1_read,
    output m1_waitrequest, m1_readdata, m1_readdatavalid,
    input  out_data, out_valid,
    output out_ready
  );
endinterface

// File: rtl/voxel_fetch_master.sv
// Avalon-MM byte read master: fetches word_count 32-bit words from base_addr,
// assembles them little-endian and streams them out through a credit-guarded FIFO.
module voxel_fetch_master #(
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic [31:0]                 base_addr,
  input  logic [31:0]                 word_count,
  output logic                        busy,
  output logic                        done,
  voxel_fetch_master_if.master        bus
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [31:0] CREDIT_MAX = 32'(FIFO_DEPTH * 4);
  localparam logic [31:0] OS_MAX     = 32'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t        state, state_nx;
  logic [31:0]   addr;
  logic [31:0]   bytes_to_issue;
  logic [29:0]   words_left;
  logic [OW-1:0] outstanding;
  logic [1:0]    byte_idx;
  logic [23:0]   asm_q;
  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_count;
  logic [31:0]   in_use;
  logic          active, issue, accept, resp, push, pop;
  logic          unused_wc;

  assign unused_wc = ^word_count[31:30];

  // Every byte already requested, being assembled or buffered holds a FIFO slot,
  // so a read is only issued while a free byte slot remains.
  always_comb begin
    active = (state == ISSUE) || (state == DRAIN);
    in_use = (32'(fifo_count) << 2) + 32'(byte_idx) + 32'(outstanding);
    issue  = (state == ISSUE) && (bytes_to_issue != '0) &&
             (32'(outstanding) < OS_MAX) && (in_use < CREDIT_MAX);
    accept = issue && !bus.m1_waitrequest;
    resp   = active && bus.m1_readdatavalid && (outstanding != '0);
    push   = resp && (byte_idx == 2'd3);
    pop    = (fifo_count != '0) && bus.out_ready;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (word_count[29:0] == '0) ? DONE : ISSUE;
      ISSUE:   if (accept && (bytes_to_issue == 32'd1)) state_nx = DRAIN;
      DRAIN:   if (pop && (words_left == 30'd1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.m1_read    = issue;
  assign bus.m1_address = addr;
  assign bus.out_valid  = (fifo_count != '0);
  assign bus.out_data   = fifo_mem[rd_ptr];
  assign busy           = active;
  assign done           = (state == DONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      addr           <= '0;
      bytes_to_issue <= '0;
      words_left     <= '0;
      outstanding    <= '0;
      byte_idx       <= '0;
      asm_q          <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_count     <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      state <= state_nx;

      if ((state == IDLE) && start) begin
        addr           <= base_addr;
        bytes_to_issue <= {word_count[29:0], 2'b00};
        words_left     <= word_count[29:0];
      end else if (accept) begin
        addr           <= addr + 32'd1;
        bytes_to_issue <= bytes_to_issue - 32'd1;
      end

      case ({accept, resp})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: ;
      endcase

      if (resp) begin
        byte_idx <= byte_idx + 2'd1;
        case (byte_idx)
          2'd0:    asm_q[7:0]   <= bus.m1_readdata;
          2'd1:    asm_q[15:8]  <= bus.m1_readdata;
          2'd2:    asm_q[23:16] <= bus.m1_readdata;
          default: ;
        endcase
      end

      if (push) begin
        fifo_mem[wr_ptr] <= {bus.m1_readdata, asm_q};
        wr_ptr           <= wr_ptr + PW'(1);
      end

      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        if (active) words_left <= words_left - 30'd1;
      end

      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_voxel_fetch_master.sv
// Self-checking bench for voxel_fetch_master: byte memory model on the m1 side,
// scoreboards for issued addresses and streamed words.
module tb_voxel_fetch_master;
  logic        clock = 1'b0;
  logic        reset, start;
  logic [31:0] base_addr, word_count;
  logic        busy, done;

  voxel_fetch_master_if bus();

  voxel_fetch_master #(.FIFO_DEPTH(4), .MAX_OUTSTANDING(8)) dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
    .word_count(word_count), .busy(busy), .done(done), .bus(bus)
  );

  always #5 clock = ~clock;

  typedef struct { int due; logic [7:0] data; } resp_t;

  int          n_cmp = 0, n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] addr_q[$];
  resp_t       rq[$];
  int          cyc = 0, lat = 1, stall_left = 0, acc_cnt = 0;
  int          tb_os = 0, max_os = 0, done_cnt = 0;
  bit          stray_req = 0, rd_seen = 0, ov_seen = 0;

  // Memory contents: byte at address a is ((a[7:0]+1) * 0x11) mod 256.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [7:0] n;
    n = a[7:0] + 8'd1;
    return 8'(n * 8'h11);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Avalon slave: optional waitrequest stall, fixed read latency, in-order data.
  initial begin : slave
    logic [31:0] held;
    bit          stalled;
    int          r_now, a_now;
    held = '0;
    stalled = 0;
    bus.m1_waitrequest   = 1'b0;
    bus.m1_readdatavalid = 1'b0;
    bus.m1_readdata      = '0;
    forever begin
      @(negedge clock);
      cyc++;
      r_now = 0;
      a_now = 0;
      if (rq.size() != 0 && rq[0].due <= cyc) begin
        bus.m1_readdatavalid = 1'b1;
        bus.m1_readdata      = rq[0].data;
        void'(rq.pop_front());
        r_now = 1;
      end else if (stray_req) begin
        bus.m1_readdatavalid = 1'b1;
        bus.m1_readdata      = 8'hEE;
        stray_req = 0;
      end else begin
        bus.m1_readdatavalid = 1'b0;
        bus.m1_readdata      = 8'h5A;
      end
      if (bus.m1_read) rd_seen = 1;
      if (stalled) begin
        check("hold_read", 32'(bus.m1_read), 32'd1);
        check("hold_addr", bus.m1_address, held);
      end
      if (!reset && bus.m1_read && stall_left > 0) begin
        bus.m1_waitrequest = 1'b1;
        stall_left--;
        held = bus.m1_address;
        stalled = 1;
      end else begin
        bus.m1_waitrequest = 1'b0;
        stalled = 0;
      end
      if (!reset && bus.m1_read && !bus.m1_waitrequest) begin
        a_now = 1;
        acc_cnt++;
        rq.push_back('{due: cyc + lat, data: mem_byte(bus.m1_address)});
        if (addr_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL read_unexpected: got address %h, required no read", bus.m1_address);
        end else begin
          check("read_addr", bus.m1_address, addr_q.pop_front());
        end
      end
      tb_os = tb_os + a_now - r_now;
      if (tb_os > max_os) max_os = tb_os;
    end
  end

  // Stream monitor: every accepted word is compared against the scoreboard head.
  initial begin : monitor
    forever begin
      @(negedge clock);
      if (done) done_cnt++;
      if (bus.out_valid) ov_seen = 1;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL word_unexpected: got %h, required no word", bus.out_data);
        end else begin
          check("out_word", bus.out_data, exp_q.pop_front());
        end
      end
    end
  end

  task automatic launch(input logic [31:0] base, input logic [31:0] cnt);
    for (int unsigned i = 0; i < cnt * 4; i++) addr_q.push_back(base + i);
    done_cnt   = 0;
    start      = 1'b1;
    base_addr  = base;
    word_count = cnt;
    tick();
    start      = 1'b0;
    base_addr  = 32'hDEADBEEF;
    word_count = 32'h5;
    check("busy_after_start", 32'(busy), 32'(cnt != 0));
  endtask

  task automatic finish_fetch(output int waited);
    bit got;
    got = 0;
    waited = 0;
    while (!got && waited < 3000) begin
      if (done) got = 1;
      else begin
        tick();
        waited++;
      end
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: got no done in %0d cycles, required done", waited);
    end
    check("words_left_at_done", 32'(exp_q.size()), 32'd0);
    check("reads_left_at_done", 32'(addr_q.size()), 32'd0);
    tick();
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("done_low", 32'(done), 32'd0);
    check("busy_low", 32'(busy), 32'd0);
  endtask

  task automatic run_fetch(input logic [31:0] base, input logic [31:0] cnt, output int waited);
    launch(base, cnt);
    finish_fetch(waited);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_m1_read"},   32'(bus.m1_read),   32'd0);
    check({tag, "_m1_addr"},   bus.m1_address,     32'd0);
    check({tag, "_busy"},      32'(busy),          32'd0);
    check({tag, "_done"},      32'(done),          32'd0);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_out_data"},  bus.out_data,       32'd0);
  endtask

  initial begin : main
    int w;
    reset         = 1'b1;
    start         = 1'b0;
    base_addr     = '0;
    word_count    = '0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    check_reset_vals("reset");
    reset = 1'b0;

    // Basic fetch
    exp_q.push_back(32'h44332211);
    exp_q.push_back(32'h88776655);
    run_fetch(32'h100, 32'd2, w);

    // Waitrequest stall on the first read
    stall_left = 3;
    exp_q.push_back(32'h44332211);
    run_fetch(32'h100, 32'd1, w);
    check("stall_consumed", 32'(stall_left), 32'd0);

    // Back-pressure: the FIFO fills and issue stops at 16 bytes
    bus.out_ready = 1'b0;
    acc_cnt = 0;
    foreach (exp_q[i]) ;
    exp_q.push_back(32'h44332211); exp_q.push_back(32'h88776655);
    exp_q.push_back(32'hCCBBAA99); exp_q.push_back(32'h10FFEEDD);
    exp_q.push_back(32'h54433221); exp_q.push_back(32'h98877665);
    exp_q.push_back(32'hDCCBBAA9); exp_q.push_back(32'h200FFEED);
    launch(32'h100, 32'd8);
    repeat (60) tick();
    check("bp_bytes_accepted", 32'(acc_cnt), 32'd16);
    check("bp_read_halted", 32'(bus.m1_read), 32'd0);
    check("bp_out_valid", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    finish_fetch(w);
    check("bp_total_bytes", 32'(acc_cnt), 32'd32);

    // Long latency: outstanding reads saturate at 8
    lat = 10;
    tb_os = 0;
    max_os = 0;
    exp_q.push_back(32'h44332211); exp_q.push_back(32'h88776655);
    exp_q.push_back(32'hCCBBAA99); exp_q.push_back(32'h10FFEEDD);
    run_fetch(32'h100, 32'd4, w);
    check("max_outstanding", 32'(max_os), 32'd8);
    lat = 1;

    // Zero count: done one cycle after start, no reads, no output
    rd_seen = 0;
    ov_seen = 0;
    run_fetch(32'h100, 32'd0, w);
    check("zero_done_latency", 32'(w), 32'd0);
    check("zero_no_read", 32'(rd_seen), 32'd0);
    check("zero_no_out_valid", 32'(ov_seen), 32'd0);

    // Stray response while idle must not disturb assembly; then an address wrap
    stray_req = 1;
    repeat (3) tick();
    check("stray_out_valid", 32'(bus.out_valid), 32'd0);
    exp_q.push_back(32'h221100EF);
    run_fetch(32'hFFFFFFFE, 32'd1, w);

    // Reset with 5 bytes accepted and 3 still in flight
    lat = 3;
    acc_cnt = 0;
    launch(32'h180, 32'd2);
    for (int i = 0; i < 50 && acc_cnt < 5; i++) tick();
    check("accepted_before_reset", 32'(acc_cnt), 32'd5);
    reset = 1'b1;
    addr_q.delete();
    exp_q.delete();
    tick();
    check_reset_vals("midreset");
    reset = 1'b0;
    ov_seen = 0;
    repeat (6) tick();
    check("late_resp_busy", 32'(busy), 32'd0);
    check("late_resp_out_valid", 32'(ov_seen), 32'd0);
    lat = 1;
    exp_q.push_back(32'h44332211);
    run_fetch(32'h200, 32'd1, w);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
